display_capture: RTL and testbench
==================================

// Module: display_capture
// PURPOSE
//  Receive-side counterpart to the stopwatch display path: watches the scanned
//  7-seg bus (anode, seg, decimal_p) and rebuilds the four hex digits shown.
//  Inverts the hex-to-segment encoding and de-multiplexes the anode scan.
//  Used as a board self-check and as the scoreboard front end in top-level benches.
//  Only a segment pattern held stable for a programmable dwell is accepted.
// PARAMETERS
//  STABLE_CYCLES   16         consecutive identical samples before a digit is committed (>=2)
//  TIMEOUT_CYCLES  2_000_000  cycles with no commit before stale asserts
// PORTS
//  clock          in   1  system clock (100 MHz)
//  reset          in   1  asynchronous, active-high reset
//  anode          in   4  digit enables, active-low; anode[0] = tenths ... anode[3] = minutes
//  seg            in   7  segments, active-low, {g,f,e,d,c,b,a}
//  decimal_p      in   1  decimal point, active-low
//  digit0..digit3 out  4  decoded hex per digit position (digit0 = tenths)
//  dp_capt        out  4  captured decimal point per digit, active-high
//  digit_valid    out  4  last commit for that position decoded to a legal code
//  frame_valid    out  1  all four digit_valid bits set
//  frame_strobe   out  1  one-cycle pulse when a complete scan frame has been captured
//  illegal_pulse  out  1  one-cycle pulse when an unrecognised pattern is committed
//  stale          out  1  no commit for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//  - Reset (async): all outputs 0; sample regs = idle (anode 4'hF, seg 7'h7F, dp 1);
//    stability counter, timeout counter and frame-seen mask = 0.
//  - Sampling: the anode, seg and decimal_p inputs are registered once per clock.
//    Compare each sample with the previous sample.
//  - Selected: sampled anode has exactly one bit low.
//  - Stability counter:
//    - Reset to 0 when the current sample differs from the previous one, or is not Selected.
//    - Otherwise increment, saturating at STABLE_CYCLES.
//  - Commit: a one-cycle event when the counter transitions to STABLE_CYCLES-1.
//    This gives exactly one commit per dwell, however long the dwell lasts.
//    Outputs update on the clock edge after the commit cycle.
//  - Decode table (seg hex -> value): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7
//    00->8 10->9 08->A 03->b 46->C 21->d 06->E 0E->F.
//  - On commit to position i:
//    - Legal pattern: digit_i = decoded value; digit_valid[i] = 1; dp_capt[i] = ~decimal_p.
//    - Illegal pattern (includes blank 7F): digit_i holds; digit_valid[i] = 0; illegal_pulse = 1.
//  - Frame tracking:
//    - Every commit sets bit i of the frame-seen mask.
//    - A commit to position 0 while mask bits 3..1 are all set pulses frame_strobe and
//      clears the mask to 4'b0001.
//    - A commit to position 0 otherwise sets the mask to 4'b0001, so partial frames
//      never strobe.
//  - frame_valid = &digit_valid (combinational from registers).
//  - Timeout counter:
//    - Cleared on every commit; otherwise increments, saturating.
//    - stale = 1 once the count reaches TIMEOUT_CYCLES; stale = 0 on the next commit.
//  - Boundary cases:
//    - Multi-hot anode, or all anode bits high (blink-off / blanking): no commit,
//      counter cleared, outputs hold.
//    - Segment glitch mid-dwell: counter restarts and needs STABLE_CYCLES fresh samples.
//    - Reset mid-dwell: immediate return to the reset state; the partial dwell is lost.
// TESTING
//  1. Reset, then scan 4'hE/seg 40, 4'hD/seg 79, 4'hB/seg 24, 4'h7/seg 30, each held 32 cycles.
//     Required: digit3..0 = 3,2,1,0; frame_valid = 1; frame_strobe pulses once at the
//     next tenths commit.
//  2. Hold anode 4'hE with seg 12 for 15 cycles, then change seg.
//     Required: no commit; digit0 and digit_valid unchanged.
//  3. Drive anode 4'hB with seg 7'h55.
//     Required: illegal_pulse for 1 cycle; digit_valid[2] = 0; digit2 holds; frame_valid = 0.
//  4. Drive anode 4'hC (two digits low), or 4'hF, for 100 cycles.
//     Required: no commit; all outputs hold.
//  5. Use TIMEOUT_CYCLES = 100 and stop scanning.
//     Required: stale = 1 at 100 cycles after the last commit; stale = 0 after the next
//     legal commit.
//  6. Assert reset mid-dwell, deassert, then scan digit 8 (seg 00) at position 1.
//     Required: all outputs 0 during reset; afterwards digit1 = 8, dp_capt[1] matches
//     ~decimal_p.

Source files
------------

// File: rtl/display_capture.sv
// display_capture
//   Rebuilds the four hex digits shown on a scanned, active-low 7-segment bus.
//   Each clock the bus is registered and compared with the previous sample; a
//   pattern must stay identical (with exactly one anode low) for STABLE_CYCLES
//   consecutive samples before it is committed to its digit position.
//
// Ports
//   clock          in   1  system clock
//   reset          in   1  asynchronous, active-high reset
//   anode          in   4  digit enables, active-low; anode[0] = tenths
//   seg            in   7  segments, active-low, {g,f,e,d,c,b,a}
//   decimal_p      in   1  decimal point, active-low
//   digit0..digit3 out  4  decoded hex value per position (digit0 = tenths)
//   dp_capt        out  4  captured decimal point per position, active-high
//   digit_valid    out  4  last commit to that position was a legal code
//   frame_valid    out  1  all four digit_valid bits set
//   frame_strobe   out  1  one-cycle pulse when a full scan frame completed
//   illegal_pulse  out  1  one-cycle pulse when an unknown pattern committed
//   stale          out  1  no commit for TIMEOUT_CYCLES cycles

module display_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] anode,
  input  logic [6:0] seg,
  input  logic       decimal_p,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_capt,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       frame_strobe,
  output logic       illegal_pulse,
  output logic       stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  // sample pipeline: current sample and the one before it
  logic [3:0] samp_anode;
  logic [6:0] samp_seg;
  logic       samp_dp;
  logic [3:0] prev_anode;
  logic [6:0] prev_seg;
  logic       prev_dp;

  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] stab_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       seen_mask;
  logic [3:0]       digit_r [4];

  logic       same_sample;
  logic       selected;
  logic [1:0] pos;
  logic       commit;
  logic [3:0] dec_val;
  logic       dec_legal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_anode <= 4'hF;
      samp_seg   <= 7'h7F;
      samp_dp    <= 1'b1;
      prev_anode <= 4'hF;
      prev_seg   <= 7'h7F;
      prev_dp    <= 1'b1;
    end else begin
      samp_anode <= anode;
      samp_seg   <= seg;
      samp_dp    <= decimal_p;
      prev_anode <= samp_anode;
      prev_seg   <= samp_seg;
      prev_dp    <= samp_dp;
    end
  end

  assign same_sample = ({samp_anode, samp_seg, samp_dp} == {prev_anode, prev_seg, prev_dp});

  // exactly one anode low selects a position; blanking and multi-hot do not
  always_comb begin
    selected = 1'b1;
    pos      = 2'd0;
    case (samp_anode)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: selected = 1'b0;
    endcase
  end

  always_comb begin
    stab_cnt_nxt = stab_cnt;
    if (!same_sample || !selected) begin
      stab_cnt_nxt = '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt_nxt = stab_cnt + CNT_W'(1);
    end
  end

  // Fires only on the S-2 -> S-1 step; saturation at S keeps a long dwell
  // from ever reaching that step twice.
  assign commit = same_sample && selected && (stab_cnt == CNT_PRE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt_nxt;
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    case (samp_seg)
      7'h40:   dec_val = 4'h0;
      7'h79:   dec_val = 4'h1;
      7'h24:   dec_val = 4'h2;
      7'h30:   dec_val = 4'h3;
      7'h19:   dec_val = 4'h4;
      7'h12:   dec_val = 4'h5;
      7'h02:   dec_val = 4'h6;
      7'h78:   dec_val = 4'h7;
      7'h00:   dec_val = 4'h8;
      7'h10:   dec_val = 4'h9;
      7'h08:   dec_val = 4'hA;
      7'h03:   dec_val = 4'hB;
      7'h46:   dec_val = 4'hC;
      7'h21:   dec_val = 4'hD;
      7'h06:   dec_val = 4'hE;
      7'h0E:   dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_r[0]    <= 4'h0;
      digit_r[1]    <= 4'h0;
      digit_r[2]    <= 4'h0;
      digit_r[3]    <= 4'h0;
      dp_capt       <= 4'h0;
      digit_valid   <= 4'h0;
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= 1'b0;
      if (commit) begin
        if (dec_legal) begin
          digit_r[pos]     <= dec_val;
          digit_valid[pos] <= 1'b1;
          dp_capt[pos]     <= ~samp_dp;
        end else begin
          digit_valid[pos] <= 1'b0;
          illegal_pulse    <= 1'b1;
        end
      end
    end
  end

  // A frame is only complete when positions 3..1 were all seen since the
  // previous tenths commit; a tenths commit always restarts the mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_mask    <= 4'h0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (commit) begin
        if (pos == 2'd0) begin
          frame_strobe <= &seen_mask[3:1];
          seen_mask    <= 4'b0001;
        end else begin
          seen_mask[pos] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (commit) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign stale       = (tmo_cnt == TMO_MAX);
  assign frame_valid = &digit_valid;

  assign digit0 = digit_r[0];
  assign digit1 = digit_r[1];
  assign digit2 = digit_r[2];
  assign digit3 = digit_r[3];

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture
//   Directed scan sequences against display_capture with a run-length model of
//   the bus: a selected pattern seen on STABLE consecutive clock edges commits
//   on the following edge. Outputs are compared with the model every negedge,
//   and literal expectations pin the model at the end of each scenario.

module tb_display_capture;

  localparam int STABLE = 16;
  localparam int TMO    = 100;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] anode = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic       decimal_p = 1'b1;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_capt, digit_valid;
  logic       frame_valid, frame_strobe, illegal_pulse, stale;

  display_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .anode        (anode),
    .seg          (seg),
    .decimal_p    (decimal_p),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .dp_capt      (dp_capt),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .frame_strobe (frame_strobe),
    .illegal_pulse(illegal_pulse),
    .stale        (stale)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int illegal_cnt = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int v = 0; v < 16; v++) begin
      if (SEG_TAB[v] == s) return v;
    end
    return -1;
  endfunction

  function automatic int pos_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a == ~(4'b0001 << i)) return i;
    end
    return -1;
  endfunction

  // model state
  logic [3:0]  m_digit [4];
  logic [3:0]  m_dp, m_valid, m_seen;
  logic        m_strobe, m_illegal;
  int          since, run_len, mp, mv;
  logic [11:0] last_in, cur_in;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
      m_dp = 4'h0; m_valid = 4'h0; m_seen = 4'h0;
      m_strobe = 1'b0; m_illegal = 1'b0;
      since = 0; run_len = 0;
      last_in = {4'hF, 7'h7F, 1'b1};
    end else begin
      m_strobe = 1'b0;
      m_illegal = 1'b0;
      mp = pos_of(last_in[11:8]);
      if (run_len == STABLE && mp >= 0) begin
        mv = decode(last_in[7:1]);
        if (mv >= 0) begin
          m_digit[mp] = mv[3:0];
          m_valid[mp] = 1'b1;
          m_dp[mp] = ~last_in[0];
        end else begin
          m_valid[mp] = 1'b0;
          m_illegal = 1'b1;
        end
        if (mp == 0) begin
          if (m_seen[3:1] == 3'b111) m_strobe = 1'b1;
          m_seen = 4'b0001;
        end else begin
          m_seen[mp] = 1'b1;
        end
        since = 0;
      end else if (since < TMO) begin
        since++;
      end
      cur_in = {anode, seg, decimal_p};
      if (cur_in == last_in) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_len = 1;
      end
      last_in = cur_in;
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      check("digits", {16'h0, digit3, digit2, digit1, digit0},
            {16'h0, m_digit[3], m_digit[2], m_digit[1], m_digit[0]});
      check("dp_capt", {28'h0, dp_capt}, {28'h0, m_dp});
      check("digit_valid", {28'h0, digit_valid}, {28'h0, m_valid});
      check("frame_valid", {31'h0, frame_valid}, {31'h0, &m_valid});
      check("frame_strobe", {31'h0, frame_strobe}, {31'h0, m_strobe});
      check("illegal_pulse", {31'h0, illegal_pulse}, {31'h0, m_illegal});
      check("stale", {31'h0, stale}, {31'h0, (since >= TMO)});
    end
    if (frame_strobe) strobe_cnt++;
    if (illegal_pulse) illegal_cnt++;
  end

  // inputs are held for exactly n sampling edges; returns 2 ns after the last
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    anode = a;
    seg = s;
    decimal_p = d;
    repeat (n) @(posedge clock);
    #2;
  endtask

  function automatic logic [15:0] digits_now();
    return {digit3, digit2, digit1, digit0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t required below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ill0;
    run_cmp = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs",
          {9'h0, digits_now(), dp_capt, digit_valid, frame_valid, frame_strobe, illegal_pulse, stale},
          32'h0);
    reset = 1'b0;

    // 1: full frame, decimal point on the seconds-tenths... position 2
    hold(4'hE, 7'h40, 1'b1, 32);
    hold(4'hD, 7'h79, 1'b1, 32);
    hold(4'hB, 7'h24, 1'b0, 32);
    hold(4'h7, 7'h30, 1'b1, 32);
    check("strobe_before_tenths", strobe_cnt, 0);
    hold(4'hE, 7'h40, 1'b1, 32);
    check("t1_digits", {16'h0, digits_now()}, 32'h3210);
    check("t1_frame_valid", {31'h0, frame_valid}, 32'h1);
    check("t1_dp_capt", {28'h0, dp_capt}, 32'h4);
    check("t1_strobe_count", strobe_cnt, 1);

    // 2: dwell one sample short of commit
    hold(4'hE, 7'h12, 1'b1, 15);
    hold(4'hF, 7'h7F, 1'b1, 20);
    check("t2_digit0", {28'h0, digit0}, 32'h0);
    check("t2_valid", {28'h0, digit_valid}, 32'hF);

    // glitch mid-dwell restarts the count
    hold(4'hD, 7'h19, 1'b1, 10);
    hold(4'hD, 7'h18, 1'b1, 1);
    hold(4'hD, 7'h19, 1'b1, 15);
    check("glitch_no_commit_yet", {28'h0, digit1}, 32'h1);
    hold(4'hD, 7'h19, 1'b1, 5);
    check("glitch_commit", {28'h0, digit1}, 32'h4);

    // 3: illegal pattern at position 2
    ill0 = illegal_cnt;
    hold(4'hB, 7'h55, 1'b1, 32);
    check("t3_illegal_count", illegal_cnt - ill0, 1);
    check("t3_valid", {28'h0, digit_valid}, 32'hB);
    check("t3_digit2", {28'h0, digit2}, 32'h2);
    check("t3_frame_valid", {31'h0, frame_valid}, 32'h0);

    // full decode table at position 3
    for (int k = 0; k < 16; k++) begin
      hold(4'h7, SEG_TAB[k], k[0], 20);
      check("sweep_digit3", {28'h0, digit3}, k);
    end

    // 4: multi-hot and blanked anode
    hold(4'hC, 7'h40, 1'b1, 100);
    hold(4'hF, 7'h40, 1'b1, 100);
    check("t4_digits", {16'h0, digits_now()}, 32'hF240);
    check("t4_valid", {28'h0, digit_valid}, 32'hB);
    check("t4_dp", {28'h0, dp_capt}, 32'h4);

    // 5: timeout after the last commit
    anode = 4'hE; seg = 7'h30; decimal_p = 1'b0;
    for (int k = 1; k <= 117; k++) begin
      @(posedge clock);
      #2;
      if (k == 16) check("t5_stale_before_commit", {31'h0, stale}, 32'h1);
      if (k == 17) check("t5_stale_cleared", {31'h0, stale}, 32'h0);
      if (k == 20) anode = 4'hF;
      if (k == 116) check("t5_stale_at_99", {31'h0, stale}, 32'h0);
      if (k == 117) check("t5_stale_at_100", {31'h0, stale}, 32'h1);
    end
    hold(4'hD, 7'h00, 1'b1, 16);
    check("t5_still_stale", {31'h0, stale}, 32'h1);
    hold(4'hD, 7'h00, 1'b1, 1);
    check("t5_stale_after_commit", {31'h0, stale}, 32'h0);
    check("t5_digit1", {28'h0, digit1}, 32'h8);

    // 6: reset mid-dwell
    hold(4'hD, 7'h00, 1'b0, 8);
    reset = 1'b1;
    #1;
    check("t6_in_reset",
          {9'h0, digits_now(), dp_capt, digit_valid, frame_valid, frame_strobe, illegal_pulse, stale},
          32'h0);
    hold(4'hD, 7'h00, 1'b0, 2);
    reset = 1'b0;
    hold(4'hD, 7'h00, 1'b0, 32);
    check("t6_digits", {16'h0, digits_now()}, 32'h0080);
    check("t6_dp", {28'h0, dp_capt}, 32'h2);
    check("t6_valid", {28'h0, digit_valid}, 32'h2);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
